// File: rtl/csc_pkg.sv
// csc_pkg: register map and arithmetic helpers shared by the colour-space
// converter (identity coefficient, unsigned output saturation).
package csc_pkg;

    localparam logic [3:0] CSC_ADDR_C00   = 4'd0;
    localparam logic [3:0] CSC_ADDR_C22   = 4'd8;
    localparam logic [3:0] CSC_ADDR_BIAS0 = 4'd9;
    localparam logic [3:0] CSC_ADDR_BIAS1 = 4'd10;
    localparam logic [3:0] CSC_ADDR_BIAS2 = 4'd11;
    localparam logic [3:0] CSC_ADDR_MODE  = 4'd12;

    // Fixed-point 1.0 for a coefficient with frac_bits fractional bits.
    function automatic logic [31:0] csc_ident(input int unsigned frac_bits);
        return 32'd1 << frac_bits;
    endfunction

    // Clamp a signed value into [0, 2^dw-1].
    function automatic logic [31:0] csc_sat(
        input logic signed [31:0] v,
        input int unsigned        dw
    );
        logic signed [31:0] mx;
        mx = (32'sd1 <<< dw) - 32'sd1;
        if (v < 0)
            return 32'd0;
        if (v > mx)
            return mx;
        return v;
    endfunction

endpackage

// File: rtl/csc_mac3.sv
// csc_mac3: one output row of the 3x3 matrix. S1 registers three signed
// products; S2 registers the row sum rounded half-up and shifted by FRAC_BITS.
// Ports: clk, rstn, en (stage advance), coef {c2,c1,c0}, x {x2,x1,x0} unsigned,
// sum (signed, rounded row result, valid one cycle after S1).
module csc_mac3 #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 12,
    parameter int FRAC_BITS  = 8
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   en,
    input  logic [3*COEF_WIDTH-1:0]                coef,
    input  logic [3*DATA_WIDTH-1:0]                x,
    output logic signed [COEF_WIDTH+DATA_WIDTH+2:0] sum
);

    localparam int PW = COEF_WIDTH + DATA_WIDTH + 1;
    localparam int AW = PW + 2;
    localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC_BITS - 1);

    logic signed [PW-1:0] prod [3];
    logic signed [AW-1:0] acc;

    // Pixels are zero-extended so they multiply as non-negative signed values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 3; k++)
                prod[k] <= '0;
        end else if (en) begin
            for (int k = 0; k < 3; k++)
                prod[k] <= PW'(signed'(coef[k*COEF_WIDTH +: COEF_WIDTH]))
                         * PW'(signed'({1'b0, x[k*DATA_WIDTH +: DATA_WIDTH]}));
        end
    end

    always_comb
        acc = AW'(prod[0]) + AW'(prod[1]) + AW'(prod[2]) + HALF;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            sum <= '0;
        else if (en)
            sum <= acc >>> FRAC_BITS;
    end

endmodule

// File: rtl/csc_stream_pipe.sv
// csc_stream_pipe: 3-stage colour-space converter with valid/ready stream,
// SOF/EOL sideband and double-buffered coefficient/bias/bypass banks.
// Ports: clk, rstn; cfg write (i_cfg_we/addr/wdata), i_cfg_commit,
// o_cfg_pending; input stream i_valid/o_ready/i_sof/i_eol/i_data;
// output stream o_valid/i_ready/o_sof/o_eol/o_data.
module csc_stream_pipe
    import csc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 12,
    parameter int FRAC_BITS  = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_cfg_we,
    input  logic [3:0]              i_cfg_addr,
    input  logic [COEF_WIDTH-1:0]   i_cfg_wdata,
    input  logic                    i_cfg_commit,
    output logic                    o_cfg_pending,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_sof,
    input  logic                    i_eol,
    input  logic [3*DATA_WIDTH-1:0] i_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_sof,
    output logic                    o_eol,
    output logic [3*DATA_WIDTH-1:0] o_data
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = COEF_WIDTH;
    localparam int AW = CW + DW + 3;
    localparam logic [CW-1:0] IDENT = CW'(csc_ident(FRAC_BITS));

    logic [8:0][CW-1:0] sh_coef, sh_coef_nxt, act_coef, eff_coef;
    logic [2:0][CW-1:0] sh_bias, sh_bias_nxt, act_bias, eff_bias;
    logic               sh_byp, sh_byp_nxt, act_byp, eff_byp;
    logic               pending, pend_eff, apply;
    logic               en, accept, idle;

    logic               v1, v2, sof1, sof2, eol1, eol2, byp1, byp2;
    logic [2:0][DW-1:0] x1, x2, y;
    logic [2:0][CW-1:0] bias1, bias2;
    logic signed [AW-1:0] r [3];
    logic signed [31:0]   t [3];

    assign en      = i_ready | ~o_valid;
    assign o_ready = en;
    assign accept  = i_valid & en;
    assign idle    = ~(v1 | v2 | o_valid | accept);

    // Shadow bank as it will be after this cycle's write.
    always_comb begin
        sh_coef_nxt = sh_coef;
        sh_bias_nxt = sh_bias;
        sh_byp_nxt  = sh_byp;
        if (i_cfg_we) begin
            case (i_cfg_addr)
                CSC_ADDR_BIAS0: sh_bias_nxt[0] = i_cfg_wdata;
                CSC_ADDR_BIAS1: sh_bias_nxt[1] = i_cfg_wdata;
                CSC_ADDR_BIAS2: sh_bias_nxt[2] = i_cfg_wdata;
                CSC_ADDR_MODE:  sh_byp_nxt     = i_cfg_wdata[0];
                default:
                    if (i_cfg_addr <= CSC_ADDR_C22)
                        sh_coef_nxt[i_cfg_addr - CSC_ADDR_C00] = i_cfg_wdata;
            endcase
        end
    end

    // The applying SOF beat must already see the new bank, so S1 reads
    // the shadow view combinationally in the apply cycle.
    assign pend_eff = pending | i_cfg_commit;
    assign apply    = pend_eff & ((accept & i_sof) | idle);
    assign eff_coef = apply ? sh_coef_nxt : act_coef;
    assign eff_bias = apply ? sh_bias_nxt : act_bias;
    assign eff_byp  = apply ? sh_byp_nxt  : act_byp;
    assign o_cfg_pending = pending;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 9; i++) begin
                sh_coef[i]  <= (i % 4 == 0) ? IDENT : '0;
                act_coef[i] <= (i % 4 == 0) ? IDENT : '0;
            end
            sh_bias  <= '0;
            act_bias <= '0;
            sh_byp   <= 1'b0;
            act_byp  <= 1'b0;
            pending  <= 1'b0;
        end else begin
            sh_coef <= sh_coef_nxt;
            sh_bias <= sh_bias_nxt;
            sh_byp  <= sh_byp_nxt;
            if (apply) begin
                act_coef <= sh_coef_nxt;
                act_bias <= sh_bias_nxt;
                act_byp  <= sh_byp_nxt;
            end
            pending <= pend_eff & ~apply;
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_row
        csc_mac3 #(
            .DATA_WIDTH (DW),
            .COEF_WIDTH (CW),
            .FRAC_BITS  (FRAC_BITS)
        ) u_mac (
            .clk  (clk),
            .rstn (rstn),
            .en   (en),
            .coef (eff_coef[c*3 +: 3]),
            .x    (i_data),
            .sum  (r[c])
        );
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            t[c] = 32'(r[c]) + 32'(signed'(bias2[c]));
            y[c] = byp2 ? x2[c] : DW'(csc_sat(t[c], DW));
        end
    end

    // Bias and bypass ride along with each beat so in-flight beats keep
    // the bank they entered with.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            sof1    <= 1'b0;
            sof2    <= 1'b0;
            eol1    <= 1'b0;
            eol2    <= 1'b0;
            byp1    <= 1'b0;
            byp2    <= 1'b0;
            x1      <= '0;
            x2      <= '0;
            bias1   <= '0;
            bias2   <= '0;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eol   <= 1'b0;
            o_data  <= '0;
        end else if (en) begin
            v1      <= i_valid;
            sof1    <= i_valid & i_sof;
            eol1    <= i_valid & i_eol;
            x1      <= i_data;
            bias1   <= eff_bias;
            byp1    <= eff_byp;
            v2      <= v1;
            sof2    <= sof1;
            eol2    <= eol1;
            x2      <= x1;
            bias2   <= bias1;
            byp2    <= byp1;
            o_valid <= v2;
            o_sof   <= sof2;
            o_eol   <= eol2;
            o_data  <= y;
        end
    end

endmodule

// File: tb/tb_csc_stream_pipe.sv
// tb_csc_stream_pipe: directed scenario bench for csc_stream_pipe at
// DATA_WIDTH=8, COEF_WIDTH=12, FRAC_BITS=8 with hand-computed expectations.
module tb_csc_stream_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_cfg_we;
    logic [3:0]  i_cfg_addr;
    logic [11:0] i_cfg_wdata;
    logic        i_cfg_commit;
    logic        o_cfg_pending;
    logic        i_valid;
    logic        o_ready;
    logic        i_sof;
    logic        i_eol;
    logic [23:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_sof;
    logic        o_eol;
    logic [23:0] o_data;

    int errors = 0;
    int checks = 0;

    csc_stream_pipe #(
        .DATA_WIDTH (8),
        .COEF_WIDTH (12),
        .FRAC_BITS  (8)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_cfg_we      (i_cfg_we),
        .i_cfg_addr    (i_cfg_addr),
        .i_cfg_wdata   (i_cfg_wdata),
        .i_cfg_commit  (i_cfg_commit),
        .o_cfg_pending (o_cfg_pending),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_sof         (i_sof),
        .i_eol         (i_eol),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_sof         (o_sof),
        .o_eol         (o_eol),
        .o_data        (o_data)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [11:0] d);
        i_cfg_we    = 1'b1;
        i_cfg_addr  = a;
        i_cfg_wdata = d;
        cyc();
        i_cfg_we = 1'b0;
    endtask

    task automatic cfg_commit();
        i_cfg_commit = 1'b1;
        cyc();
        i_cfg_commit = 1'b0;
    endtask

    task automatic cfg_identity();
        for (int i = 0; i < 9; i++)
            cfg_write(4'(i), (i % 4 == 0) ? 12'd256 : 12'd0);
        cfg_write(4'd9, 12'd0);
        cfg_write(4'd10, 12'd0);
        cfg_write(4'd11, 12'd0);
        cfg_write(4'd12, 12'd0);
        cfg_commit();
        cyc();
    endtask

    // Push one beat with i_ready high and wait (bounded) for its result.
    task automatic send_get(
        input  logic [23:0] d,
        output logic [23:0] q,
        output bit          ok
    );
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = d;
        i_sof   = 1'b0;
        i_eol   = 1'b0;
        cyc();
        i_valid = 1'b0;
        ok = 1'b0;
        q  = '0;
        for (int n = 0; n < 8 && !ok; n++) begin
            if (o_valid) begin
                ok = 1'b1;
                q  = o_data;
            end else begin
                cyc();
            end
        end
        cyc();
    endtask

    task automatic test_reset();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", o_valid);
        end
        checks++;
        if (o_data !== 24'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=000000", o_data);
        end
        checks++;
        if ({o_sof, o_eol} !== 2'b00) begin
            errors++;
            $display("FAIL reset_sideband got=%b exp=00", {o_sof, o_eol});
        end
        checks++;
        if (o_cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending got=%b exp=0", o_cfg_pending);
        end
    endtask

    task automatic test_identity();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_sof   = 1'b1;
        i_eol   = 1'b1;
        i_data  = {8'd50, 8'd100, 8'd200};
        cyc();
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_eol   = 1'b0;
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL lat_early n=%0d got=%b exp=0", n, o_valid);
            end
            cyc();
        end
        checks++;
        if ({o_valid, o_sof, o_eol, o_data} !== {3'b111, 8'd50, 8'd100, 8'd200}) begin
            errors++;
            $display("FAIL ident_out got=%b%b%b %h exp=111 3264c8",
                     o_valid, o_sof, o_eol, o_data);
        end
        cyc();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL ident_single got=%b exp=0", o_valid);
        end
    endtask

    task automatic test_stall();
        logic [23:0] exp_q [10];
        logic [23:0] prev;
        bit          hold;
        int          sent;
        int          rcv;
        for (int i = 0; i < 10; i++)
            exp_q[i] = {8'(255 - 5 * i), 8'(13 * i), 8'(7 * i + 1)};
        hold = 1'b0;
        prev = '0;
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 80 && rcv < 10; c++) begin
            i_ready = (c % 4 == 0) || (c % 4 == 3);
            i_valid = (sent < 10);
            i_data  = exp_q[(sent < 10) ? sent : 0];
            i_sof   = (sent == 0);
            i_eol   = (sent == 9);
            #1;
            if (hold) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== prev) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d got=%b %h exp=1 %h",
                             c, o_valid, o_data, prev);
                end
            end
            checks++;
            if (o_ready !== !(o_valid && !i_ready)) begin
                errors++;
                $display("FAIL stall_ready c=%0d got=%b exp=%b",
                         c, o_ready, !(o_valid && !i_ready));
            end
            if (o_valid && i_ready) begin
                checks++;
                if ({o_sof, o_eol, o_data} !== {rcv == 0, rcv == 9, exp_q[rcv]}) begin
                    errors++;
                    $display("FAIL stall_data beat=%0d got=%b%b %h exp=%b%b %h",
                             rcv, o_sof, o_eol, o_data, rcv == 0, rcv == 9, exp_q[rcv]);
                end
                rcv++;
            end
            hold = o_valid && !i_ready;
            prev = o_data;
            if (i_valid && o_ready)
                sent++;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_eol   = 1'b0;
        i_ready = 1'b1;
        checks++;
        if (rcv != 10) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=10", rcv);
        end
        cyc();
    endtask

    task automatic test_matrix();
        logic [23:0] q;
        bit          ok;
        cfg_write(4'd1, 12'd256);
        cfg_write(4'd2, 12'd256);
        cfg_write(4'd3, 12'hF00);
        cfg_write(4'd4, 12'd0);
        cfg_commit();
        cyc();
        checks++;
        if (o_cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL mat_idle_apply got=%b exp=0", o_cfg_pending);
        end
        send_get({8'd50, 8'd100, 8'd200}, q, ok);
        checks++;
        if (!ok || q !== {8'd50, 8'd0, 8'd255}) begin
            errors++;
            $display("FAIL mat_sat ok=%0d got=%h exp=3200ff", ok, q);
        end
        cfg_write(4'd6, 12'd128);
        cfg_commit();
        send_get({8'd0, 8'd0, 8'd3}, q, ok);
        checks++;
        if (!ok || q !== {8'd2, 8'd0, 8'd3}) begin
            errors++;
            $display("FAIL mat_round ok=%0d got=%h exp=020003", ok, q);
        end
    endtask

    task automatic test_pending();
        logic [23:0] outs [7];
        logic [23:0] e;
        int          n;
        cfg_identity();
        n = 0;
        i_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            i_valid      = (k < 7);
            i_data       = {8'(60 + k), 8'(40 + k), 8'(20 + k)};
            i_sof        = (k == 0) || (k == 5);
            i_cfg_we     = (k == 1);
            i_cfg_addr   = 4'd9;
            i_cfg_wdata  = 12'd10;
            i_cfg_commit = (k == 2);
            cyc();
            if (k >= 2 && k <= 4) begin
                checks++;
                if (o_cfg_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL pend_hold k=%0d got=%b exp=1", k, o_cfg_pending);
                end
            end
            if (k == 5) begin
                checks++;
                if (o_cfg_pending !== 1'b0) begin
                    errors++;
                    $display("FAIL pend_apply got=%b exp=0", o_cfg_pending);
                end
            end
            if (o_valid && n < 7) begin
                outs[n] = o_data;
                n++;
            end
        end
        i_valid      = 1'b0;
        i_sof        = 1'b0;
        i_cfg_we     = 1'b0;
        i_cfg_commit = 1'b0;
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL pend_count got=%0d exp=7", n);
        end
        for (int k = 0; k < n; k++) begin
            e = {8'(60 + k), 8'(40 + k), 8'(20 + k + ((k >= 5) ? 10 : 0))};
            checks++;
            if (outs[k] !== e) begin
                errors++;
                $display("FAIL pend_bias beat=%0d got=%h exp=%h", k, outs[k], e);
            end
        end
    endtask

    task automatic test_bypass();
        logic [23:0] q;
        bit          ok;
        cfg_write(4'd1, 12'd100);
        cfg_write(4'd12, 12'd1);
        cfg_commit();
        send_get({8'd50, 8'd100, 8'd200}, q, ok);
        checks++;
        if (!ok || q !== {8'd50, 8'd100, 8'd200}) begin
            errors++;
            $display("FAIL byp_pass ok=%0d got=%h exp=3264c8", ok, q);
        end
        cfg_write(4'd13, 12'd0);
        cfg_write(4'd14, 12'd0);
        cfg_write(4'd15, 12'd0);
        cfg_commit();
        send_get({8'd7, 8'd9, 8'd11}, q, ok);
        checks++;
        if (!ok || q !== {8'd7, 8'd9, 8'd11}) begin
            errors++;
            $display("FAIL byp_addr_ignored ok=%0d got=%h exp=07090b", ok, q);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] q;
        bit          ok;
        // 61200/256 rounds to 239, plus bias 10.
        cfg_write(4'd12, 12'd0);
        cfg_commit();
        send_get({8'd50, 8'd100, 8'd200}, q, ok);
        checks++;
        if (!ok || q !== {8'd50, 8'd100, 8'd249}) begin
            errors++;
            $display("FAIL pre_reset_bank ok=%0d got=%h exp=3264f9", ok, q);
        end
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_valid      = 1'b1;
            i_data       = {8'(10 + k), 8'(20 + k), 8'(30 + k)};
            i_cfg_we     = (k == 1);
            i_cfg_addr   = 4'd0;
            i_cfg_wdata  = 12'd0;
            i_cfg_commit = (k == 1);
            cyc();
        end
        i_valid      = 1'b0;
        i_cfg_we     = 1'b0;
        i_cfg_commit = 1'b0;
        checks++;
        if ({o_valid, o_cfg_pending} !== 2'b11) begin
            errors++;
            $display("FAIL inflight got=%b exp=11", {o_valid, o_cfg_pending});
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_cfg_pending, o_data} !== 26'h0) begin
            errors++;
            $display("FAIL async_reset got=%b%b %h exp=00 000000",
                     o_valid, o_cfg_pending, o_data);
        end
        cyc();
        rstn = 1'b1;
        cyc();
        send_get({8'd50, 8'd100, 8'd200}, q, ok);
        checks++;
        if (!ok || q !== {8'd50, 8'd100, 8'd200}) begin
            errors++;
            $display("FAIL post_reset_ident ok=%0d got=%h exp=3264c8", ok, q);
        end
        cfg_commit();
        send_get({8'd10, 8'd20, 8'd30}, q, ok);
        checks++;
        if (!ok || q !== {8'd10, 8'd20, 8'd30}) begin
            errors++;
            $display("FAIL post_reset_shadow ok=%0d got=%h exp=0a141e", ok, q);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rstn         = 1'b0;
        i_cfg_we     = 1'b0;
        i_cfg_addr   = 4'd0;
        i_cfg_wdata  = 12'd0;
        i_cfg_commit = 1'b0;
        i_valid      = 1'b0;
        i_sof        = 1'b0;
        i_eol        = 1'b0;
        i_data       = 24'h0;
        i_ready      = 1'b0;
        repeat (3) cyc();
        test_reset();
        rstn = 1'b1;
        cyc();
        test_identity();
        test_stall();
        test_matrix();
        test_pending();
        test_bypass();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
